router_fifo: RTL
================

Name: router_fifo

Overview:
- Per-port output FIFO of the 1x3 router; three instances.
- Each sits between the synchronizer, which drives its write_enb bit and soft_reset, and the destination's read interface.
- Stores header, payload and parity bytes, each tagged with a header flag.
- Tracks the remaining packet length on the read side and reports full/empty back to the synchronizer, which uses empty as vld_out.

Parameters:
DEPTH, 16, number of entries; power of two.
DATA_W, 8, byte width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
soft_reset  input  1  synchronous flush from synchronizer timeout
write_enb  input  1  write request (one bit of synchronizer write_enb)
lfd_state  input  1  high while the header byte is being written
data_in  input  DATA_W  byte from the register stage
read_enb  input  1  read request from destination
data_out  output  DATA_W  registered read data
full  output  1  no free entry
empty  output  1  no stored entry
ovf_err  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Storage: DEPTH x (DATA_W+1) array; bit DATA_W is the header flag.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits.
  - empty = pointers equal.
  - full = MSBs differ and lower bits equal.
  - Both flags are combinational from the pointers.
- Write accepted when write_enb && !full: mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr++ (natural wrap).
- Read accepted when read_enb && !empty: data_out <= mem[rd_ptr][DATA_W-1:0] on the same edge (1-cycle latency); rd_ptr++.
- Packet counter cnt, 7 bits:
  - On an accepted read with header flag set: cnt <= data[7:2] + 1 (payload plus parity).
  - On an accepted read with flag clear and cnt != 0: cnt--.
- data_out on cycles with no accepted read: holds if cnt != 0; cleared to 0 if cnt == 0.
- Simultaneous read and write: both accepted when the flags permit; occupancy unchanged.
  - Simultaneous when full: write dropped, read accepted.
  - Simultaneous when empty: read ignored, write accepted.
- Write while full: dropped, pointers unchanged.
- Read while empty: ignored; data_out follows the cnt rule.
- soft_reset (synchronous): wr_ptr, rd_ptr, cnt and data_out go to 0. Memory is not cleared. Any same-cycle write or read is discarded.
- Priority: reset > soft_reset > normal operation.
- reset (asynchronous, any time including mid-packet): pointers, cnt and data_out go to 0; all memory entries go to 0. After reset: empty=1, full=0, ovf_err=0.

Optional Feature:
- Macro: ROUTER_FIFO_OVF_FLAG_EN.
- Defined: ovf_err is set to 1 on any cycle with write_enb && full. It stays set until reset or soft_reset.
- Undefined: ovf_err is tied to 0 and no overflow register is built.
- Port list is identical in both cases.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W default
  - HDR_FLAG_BIT index
  - LEN_MSB=7 and LEN_LSB=2 header length field bounds
  - CNT_W=7
- One sub-module is natural: router_fifo_ptr, holding the pointer pair and the full/empty generation. All other logic stays in router_fifo.

Test Plan:
1. reset pulse mid-stream with 5 entries stored -> empty=1, full=0, data_out=0 immediately, without waiting for a clock edge.
2. Write header 0x0D (len 3, lfd_state=1), payload 0xA1 0xA2 0xA3, parity 0x5C, then read 5 -> data_out sequence 0D,A1,A2,A3,5C one cycle after each read; cnt 4,3,2,1,0; data_out=0 on the next idle cycle.
3. Write 16 bytes -> full=1 after the 16th; a 17th write is dropped. Read 16 -> the original bytes come out in order, empty=1. With ROUTER_FIFO_OVF_FLAG_EN, ovf_err=1 after the 17th write.
4. Hold full, assert write_enb and read_enb together -> one read, write dropped, full goes to 0. At 8 entries, simultaneous read and write for 20 cycles -> occupancy stays 8 and pointers wrap correctly.
5. soft_reset with 7 entries and cnt=3 -> next cycle empty=1, data_out=0, cnt=0; a write in the same cycle is lost; the following header write/read works normally.
6. Read when empty -> pointers unchanged, empty stays 1, data_out=0.

Source files
------------

// File: rtl/router_pkg.sv
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared widths, header field bounds and helpers for the 1x3 router.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int DATA_W       = 8;
  localparam int HDR_FLAG_BIT = DATA_W;
  localparam int LEN_MSB      = 7;
  localparam int LEN_LSB      = 2;
  localparam int CNT_W        = 7;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [CNT_W-1:0] hdr_to_cnt(input logic [LEN_MSB:0] hdr);
    return CNT_W'(hdr[LEN_MSB:LEN_LSB]) + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_fifo_ptr.sv
// ============================================================================
//  Module   : router_fifo_ptr
//  Purpose  : Write/read pointer pair with full/empty flags and accept strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_fifo_ptr #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              full,
  output logic              empty
);

  // One extra MSB separates the full and empty cases when the addresses match.
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                 (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  // A flush discards any transfer that lands in the same cycle.
  assign wr_en = write_enb && !full  && !soft_reset;
  assign rd_en = read_enb  && !empty && !soft_reset;

  assign wr_addr = r_wr_ptr[ADDR_W-1:0];
  assign rd_addr = r_rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_fifo.sv
// ============================================================================
//  Module   : router_fifo
//  Purpose  : Per-port output FIFO of the 1x3 router with packet length tracking.
//             Optional sticky overflow flag: define ROUTER_FIFO_OVF_FLAG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = router_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              ovf_err
);

  localparam int c_addr_w = $clog2(DEPTH);

  logic [DATA_W:0]       r_mem [DEPTH];
  logic [c_addr_w-1:0]   w_wr_addr;
  logic [c_addr_w-1:0]   w_rd_addr;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [DATA_W:0]       w_rd_entry;
  logic [DATA_W-1:0]     r_data_out;
  logic [CNT_W-1:0]      r_cnt;

  router_fifo_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (c_addr_w)
  ) u_ptr (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .wr_en      (w_wr_en),
    .rd_en      (w_rd_en),
    .wr_addr    (w_wr_addr),
    .rd_addr    (w_rd_addr),
    .full       (full),
    .empty      (empty)
  );

  // Storage is wiped only by the hard reset; a flush just rewinds the pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= {lfd_state, data_in};
    end
  end

  assign w_rd_entry = r_mem[w_rd_addr];

  // Output byte is held while a packet is in flight and zeroed between packets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
      r_cnt      <= '0;
    end else if (soft_reset) begin
      r_data_out <= '0;
      r_cnt      <= '0;
    end else if (w_rd_en) begin
      r_data_out <= w_rd_entry[DATA_W-1:0];
      if (w_rd_entry[HDR_FLAG_BIT]) begin
        r_cnt <= hdr_to_cnt(w_rd_entry[LEN_MSB:0]);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (r_cnt == '0) begin
      r_data_out <= '0;
    end
  end

  assign data_out = r_data_out;

`ifdef ROUTER_FIFO_OVF_FLAG_EN
  logic r_ovf_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_err <= 1'b0;
    end else if (soft_reset) begin
      r_ovf_err <= 1'b0;
    end else if (write_enb && full) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

`default_nettype wire
